// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction memory.
// Accepts a framed byte stream (SYNC, LEN, LEN*4 payload bytes MSB-first, CHK),
// writes big-endian 32-bit words from word address 0 upward, and holds the
// core in reset until a whole frame has passed its XOR checksum.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   s_valid    stream byte valid
//   s_data     stream byte
//   s_ready    loader can take a byte (decoded from state only)
//   wr_en      instruction-memory write strobe, one cycle per word
//   wr_addr    word address of the write
//   wr_data    word being written
//   cpu_reset  core reset hold, drops once a frame is verified
//   done       frame loaded and verified (sticky until reset)
//   err        last frame rejected (sticky until the next SYNC)
module imem_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    // One extra bit so a full-memory frame (LEN = 2^ADDR_W) fits.
    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned MAX_LEN = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]       acc;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] word_cnt;
    logic [1:0]       byte_cnt;
    logic [23:0]      word_sr;   // first three bytes of the word being assembled

    logic accept;
    logic is_sync;
    logic len_bad;
    logic last_byte;
    logic last_word;

    assign accept    = s_valid & s_ready;
    assign is_sync   = (s_data == SYNC);
    assign len_bad   = (s_data == 8'd0) || (32'(s_data) > MAX_LEN);
    assign last_byte = (byte_cnt == 2'd3);
    assign last_word = (word_cnt == len - LEN_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept && is_sync) state_nxt = S_LEN;
            S_LEN:  if (accept) state_nxt = len_bad ? S_ERR : S_DATA;
            S_DATA: if (accept && last_byte && last_word) state_nxt = S_CHK;
            S_CHK:  if (accept) state_nxt = (s_data == acc) ? S_DONE : S_ERR;
            S_DONE: state_nxt = S_DONE;
            S_ERR:  if (accept && is_sync) state_nxt = S_LEN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: ready in every state except DONE, independent of s_valid.
    always_comb begin
        s_ready = 1'b1;
        if (state == S_DONE) begin
            s_ready = 1'b0;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= 8'd0;
            len       <= '0;
            word_cnt  <= '0;
            byte_cnt  <= 2'd0;
            word_sr   <= 24'd0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 32'd0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (accept) begin
                unique case (state)
                    S_IDLE, S_ERR: begin
                        if (is_sync) begin
                            acc      <= 8'd0;
                            word_cnt <= '0;
                            byte_cnt <= 2'd0;
                            err      <= 1'b0;
                        end
                    end
                    S_LEN: begin
                        if (len_bad) begin
                            err <= 1'b1;
                        end else begin
                            len <= LEN_W'(s_data);
                            acc <= s_data;
                        end
                    end
                    S_DATA: begin
                        acc      <= acc ^ s_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        word_sr  <= {word_sr[15:0], s_data};
                        if (last_byte) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= word_cnt[ADDR_W-1:0];
                            wr_data  <= {word_sr, s_data};
                            word_cnt <= word_cnt + LEN_W'(1);
                        end
                    end
                    S_CHK: begin
                        if (s_data == acc) begin
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level reference model with
// randomized payloads, lengths, checksum corruption, gaps and leading garbage.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned NWORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_reset;
    logic              done;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]        tb_mem  [NWORDS];   // what the DUT actually wrote
    logic [31:0]        exp_mem [NWORDS];   // what the model says should be there
    logic [ADDR_W+31:0] exp_q   [$];        // pending expected writes {addr, data}
    logic [ADDR_W+31:0] e;
    logic [7:0]         pl      [256];      // payload bytes for the next frame

    imem_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the next expected word.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            tb_mem[wr_addr] = wr_data;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[ADDR_W+31:32]));
                check("wr_data", wr_data, e[31:0]);
            end
        end
    end

    function automatic int pick_gap(input int gmin, input int gmax);
        return int'($urandom_range(gmax, gmin));
    endfunction

    // Entered and left at a falling edge; the byte is accepted on the rising
    // edge in between, so registered outputs reflect it on return.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int i = 0; i < gap; i++) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) check("ready_timeout", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rst_s_ready",   32'(s_ready),   32'd1);
        check("rst_wr_en",     32'(wr_en),     32'd0);
        check("rst_wr_addr",   32'(wr_addr),   32'd0);
        check("rst_wr_data",   wr_data,        32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done",      32'(done),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        exp_q.delete();
    endtask

    task automatic set_directed();
        logic [63:0] w;
        w = 64'h12345678_9ABCDEF0;
        for (int i = 0; i < 8; i++) pl[i] = w[63-8*i -: 8];
    endtask

    task automatic set_random();
        for (int i = 0; i < 256; i++) pl[i] = 8'($urandom);
    endtask

    // Sends one frame and checks the outcome the frame rules predict.
    // chk_x = 0 sends the correct checksum; otherwise it is XORed into CHK.
    task automatic send_frame(input int len, input logic [7:0] chk_x,
                              input int gmin, input int gmax, input int ngarb);
        logic [7:0] chk;
        logic [7:0] b;
        bit         good;
        for (int i = 0; i < ngarb; i++) begin
            do b = 8'($urandom); while (b == 8'hA5);
            send_byte(b, pick_gap(gmin, gmax));
        end
        send_byte(8'hA5, pick_gap(gmin, gmax));
        check("sync_err_clear", 32'(err), 32'd0);
        check("sync_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(8'(len), pick_gap(gmin, gmax));
        if (len == 0 || len > int'(NWORDS)) begin
            check("len_err",  32'(err),  32'd1);
            check("len_done", 32'(done), 32'd0);
            return;
        end
        chk = 8'(len);
        for (int w = 0; w < len; w++) begin
            exp_mem[w] = {pl[4*w], pl[4*w+1], pl[4*w+2], pl[4*w+3]};
            exp_q.push_back({ADDR_W'(w), exp_mem[w]});
            for (int k = 0; k < 4; k++) begin
                chk = chk ^ pl[4*w+k];
                send_byte(pl[4*w+k], pick_gap(gmin, gmax));
            end
        end
        check("pre_chk_done", 32'(done), 32'd0);
        good = (chk_x == 8'd0);
        send_byte(chk ^ chk_x, pick_gap(gmin, gmax));
        check("chk_done",      32'(done),      32'(good));
        check("chk_err",       32'(err),       32'(!good));
        check("chk_cpu_reset", 32'(cpu_reset), 32'(!good));
        check("wr_missing",    32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int len;
        s_valid = 1'b0;
        s_data  = 8'd0;
        do_reset();

        // Bad checksum on the reference 2-word frame (CHK 03 instead of 02).
        set_directed();
        send_frame(2, 8'h01, 0, 0, 0);

        // Length bounds.
        send_frame(0, 8'h00, 0, 0, 0);
        send_frame(8'h41, 8'h00, 0, 0, 0);

        // Random rejected frames.
        for (int r = 0; r < 4; r++) begin
            set_random();
            send_frame(int'($urandom_range(64, 1)), 8'($urandom_range(255, 1)), 0, 2,
                       int'($urandom_range(3, 0)));
        end

        // Recovery: good reference frame back to back.
        set_directed();
        send_frame(2, 8'h00, 0, 0, 0);
        check("mem0_good", tb_mem[0], 32'h12345678);
        check("mem1_good", tb_mem[1], 32'h9ABCDEF0);

        // After done: stream keeps offering bytes, nothing is accepted.
        s_valid = 1'b1;
        s_data  = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("done_s_ready",   32'(s_ready),   32'd0);
            check("done_sticky",    32'(done),      32'd1);
            check("done_cpu_reset", 32'(cpu_reset), 32'd0);
            s_data = (i == 0) ? 8'h01 : 8'($urandom);
        end
        s_valid = 1'b0;

        // Full-memory frame.
        do_reset();
        set_random();
        send_frame(64, 8'h00, 0, 0, 0);
        for (int i = 0; i < int'(NWORDS); i++) check("mem_full", tb_mem[i], exp_mem[i]);

        // Garbage prefix and 3-cycle gaps between bytes.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        check("garbage_err", 32'(err), 32'd0);
        set_directed();
        send_frame(2, 8'h00, 3, 3, 0);
        check("mem0_gap", tb_mem[0], 32'h12345678);
        check("mem1_gap", tb_mem[1], 32'h9ABCDEF0);

        // Reset in the middle of word 1; the byte offered with reset is dropped.
        do_reset();
        tb_mem[0] = 32'd0;
        set_directed();
        exp_q.push_back({ADDR_W'(0), 32'h12345678});
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 5; i++) send_byte(pl[i], 0);
        s_valid = 1'b1;
        s_data  = pl[5];
        reset   = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        s_valid = 1'b0;
        check("mid_wr_en",     32'(wr_en),     32'd0);
        check("mid_wr_addr",   32'(wr_addr),   32'd0);
        check("mid_cpu_reset", 32'(cpu_reset), 32'd1);
        check("mid_s_ready",   32'(s_ready),   32'd1);
        check("mid_mem0",      tb_mem[0],      32'h12345678);
        check("mid_wr_missing", 32'(exp_q.size()), 32'd0);
        set_random();
        send_frame(int'($urandom_range(64, 1)), 8'h00, 0, 1, 2);

        // Random good frames, each after a reset.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            set_random();
            len = int'($urandom_range(64, 1));
            send_frame(len, 8'h00, 0, 2, int'($urandom_range(3, 0)));
            for (int i = 0; i < len; i++) check("mem_rand", tb_mem[i], exp_mem[i]);
        end

        repeat (3) @(negedge clk);
        check("final_wr_missing", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory the pipelined core fetches from. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them sequentially into instruction memory from word address 0. It holds the core in reset until a complete frame passes its checksum, then releases it.

## Interface
Parameters:
- ADDR_W, 6, instruction-memory word-address width (64 words, matches fetch index pc[7:2])
- SYNC, 8'hA5, frame start byte

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- s_valid  input  1  byte on s_data is valid
- s_data  input  8  stream byte
- s_ready  output  1  loader can accept a byte this cycle
- wr_en  output  1  instruction-memory write strobe, one cycle per word
- wr_addr  output  ADDR_W  word address for the write
- wr_data  output  32  word to write
- cpu_reset  output  1  core reset hold; high until a frame loads successfully
- done  output  1  frame loaded and verified (sticky)
- err  output  1  last frame rejected (sticky until next SYNC)

## Operation
- Frame: SYNC, LEN, then LEN×4 payload bytes (MSB first per word), then CHK. LEN is in words. CHK is the XOR of LEN and all payload bytes.
- A byte is accepted on a rising edge with s_valid & s_ready.
- States:
  - IDLE: non-SYNC bytes are discarded. SYNC moves to LEN, clears the checksum accumulator, word counter and byte counter, and clears err.
  - LEN: LEN=0 or LEN>2^ADDR_W moves to ERR. Otherwise latch LEN, seed the accumulator with LEN, and move to DATA.
  - DATA: shift the byte into the word register and XOR it into the accumulator. On the 4th byte, issue the write and increment the word counter. After word LEN−1, move to CHK.
  - CHK: if the byte equals the accumulator, move to DONE. Otherwise move to ERR.
  - DONE: done=1, cpu_reset=0, s_ready=0. Only reset leaves DONE.
  - ERR: err=1, cpu_reset=1, s_ready=1. SYNC moves to LEN. Other bytes are discarded.
- Words already written are not rolled back on ERR. The core stays in reset, so stale contents are never executed.
- wr_addr counts 0..LEN−1 and never wraps within a frame.
- Reset values: s_ready=1, wr_en=0, wr_addr=0, wr_data=0, cpu_reset=1, done=0, err=0, state=IDLE.
- Reset mid-frame: abort to IDLE with the reset values above. Instruction memory is not cleared.

## Timing
- s_ready is a combinational decode of state: 1 in IDLE, LEN, DATA, CHK and ERR; 0 in DONE. It has no dependency on s_valid.
- Throughput: one byte per cycle sustained. s_valid may drop at any cycle, and counters hold while it is low.
- wr_en, wr_addr and wr_data are registered. They are valid, with wr_en high, in the cycle after the 4th byte of a word is accepted. wr_en is high for exactly one cycle per word.
- The final word's write occurs in the same cycle the loader enters CHK.
- done and cpu_reset change in the cycle after CHK is accepted (registered). The core's first fetch follows the cycle after cpu_reset falls.
- err asserts in the cycle after the failing LEN or CHK byte. It deasserts in the cycle after SYNC is accepted in ERR.
- Simultaneous reset and an accepted byte: reset wins and the byte is dropped.

## Test plan
- Good 2-word load:
  - Stimulus: A5 02 12 34 56 78 9A BC DE F0 02, back to back.
  - Required: wr_en pulse with addr 0 / 32'h12345678, then addr 1 / 32'h9ABCDEF0. done=1 and cpu_reset=0 one cycle after CHK. s_ready=0 thereafter.
- Bad checksum then recovery:
  - Stimulus: same frame with CHK=03.
  - Required: err=1, cpu_reset=1, done=0.
  - Follow-up: resend the good frame. Required: err clears the cycle after SYNC, then done=1.
- Length bounds:
  - LEN=00: err=1 and no wr_en.
  - LEN=41: err=1.
  - LEN=40 with 256 payload bytes and correct CHK: 64 writes at addr 0..63, then done.
- Framing and flow control:
  - Stimulus: 00 FF 5A before A5, and s_valid deasserted for 3 cycles between every payload byte.
  - Required: garbage bytes are ignored, and writes and data are identical to the good 2-word load.
- Reset mid-DATA:
  - Stimulus: reset asserted after A5 02 and 5 payload bytes.
  - Required: state IDLE next cycle, wr_addr=0, wr_en=0, cpu_reset=1, word 0 still present in memory. A subsequent good frame loads normally.
- After done:
  - Stimulus: A5 01 … driven with s_valid=1.
  - Required: s_ready=0, no wr_en, done stays 1.
